// File: rtl/ga_crossover_sched.sv
// Generation-level scheduler for the GA crossover stage: gates parent-pair issue,
// counts children accepted by mutation and sequences generations within a run.
module ga_crossover_sched #(
    parameter int P_W   = 8,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             sw_rst,
    input  logic [P_W-1:0]   cnfg_p,
    input  logic [GEN_W-1:0] cnfg_gen_max,
    input  logic             start,
    input  logic             pop_ready,
    input  logic             sel_parents_valid,
    output logic             sel_parents_ack,
    output logic             xo_parents_valid,
    input  logic             xo_parents_ack,
    input  logic             xo_child_valid,
    input  logic             xo_child_ack,
    output logic             busy,
    output logic             gen_start_pls,
    output logic             gen_done_pls,
    output logic             run_done_pls,
    output logic [GEN_W-1:0] gen_cnt,
    output logic [P_W-1:0]   issue_cnt,
    output logic [P_W-1:0]   child_cnt,
    output logic             err_ovf
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_POP = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        GEN_END  = 3'd4
    } state_t;

    state_t           state_q;
    logic [P_W-1:0]   p_lat_q;
    logic [P_W-1:0]   issue_cnt_q;
    logic [P_W-1:0]   child_cnt_q;
    logic [GEN_W-1:0] gmax_lat_q;
    logic [GEN_W-1:0] gen_cnt_q;
    logic [GEN_W-1:0] gen_cnt_d;
    logic             gen_start_q;
    logic             gen_done_q;
    logic             run_done_q;
    logic             err_ovf_q;

    logic             issue_hs;
    logic             child_hs;
    logic             child_window;
    logic             child_full;

    assign xo_parents_valid = sel_parents_valid && (state_q == RUN) && (issue_cnt_q != p_lat_q);
    assign sel_parents_ack  = xo_parents_ack && xo_parents_valid;
    assign issue_hs         = sel_parents_ack;
    assign child_hs         = xo_child_valid && xo_child_ack;
    assign child_window     = (state_q == RUN) || (state_q == DRAIN);
    assign child_full       = (child_cnt_q == p_lat_q);
    assign gen_cnt_d        = gen_cnt_q + 1'b1;

    assign busy          = (state_q != IDLE);
    assign gen_start_pls = gen_start_q;
    assign gen_done_pls  = gen_done_q;
    assign run_done_pls  = run_done_q;
    assign gen_cnt       = gen_cnt_q;
    assign issue_cnt     = issue_cnt_q;
    assign child_cnt     = child_cnt_q;
    assign err_ovf       = err_ovf_q;

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q     <= IDLE;
            p_lat_q     <= '0;
            gmax_lat_q  <= '0;
            issue_cnt_q <= '0;
            child_cnt_q <= '0;
            gen_cnt_q   <= '0;
            gen_start_q <= 1'b0;
            gen_done_q  <= 1'b0;
            run_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            gen_start_q <= 1'b0;
            gen_done_q  <= 1'b0;
            run_done_q  <= 1'b0;

            if (issue_hs) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        p_lat_q    <= cnfg_p;
                        gmax_lat_q <= cnfg_gen_max;
                        gen_cnt_q  <= '0;
                        err_ovf_q  <= 1'b0;
                        // An empty run completes immediately without leaving IDLE.
                        if ((cnfg_p == '0) || (cnfg_gen_max == '0)) begin
                            run_done_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_POP;
                        end
                    end
                end
                WAIT_POP: begin
                    if (pop_ready) begin
                        state_q     <= RUN;
                        issue_cnt_q <= '0;
                        child_cnt_q <= '0;
                        gen_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue_cnt_q == p_lat_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (child_full) begin
                        state_q    <= GEN_END;
                        gen_done_q <= 1'b1;
                    end
                end
                GEN_END: begin
                    gen_cnt_q <= gen_cnt_d;
                    if (gen_cnt_d == gmax_lat_q) begin
                        state_q    <= IDLE;
                        run_done_q <= 1'b1;
                    end else begin
                        state_q <= WAIT_POP;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Placed after the FSM so an overflow in the same cycle as start still flags.
            if (child_hs) begin
                if (child_window && !child_full) begin
                    child_cnt_q <= child_cnt_q + 1'b1;
                end else begin
                    err_ovf_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ga_crossover_sched.sv
// Self-checking bench for ga_crossover_sched: config/gating tables, directed
// corner sequences and randomized runs against an event-level reference model.
module tb_ga_crossover_sched;

    localparam int P_W   = 8;
    localparam int GEN_W = 16;

    logic             clk;
    logic             sw_rst;
    logic [P_W-1:0]   cnfg_p;
    logic [GEN_W-1:0] cnfg_gen_max;
    logic             start;
    logic             pop_ready;
    logic             sel_parents_valid;
    logic             sel_parents_ack;
    logic             xo_parents_valid;
    logic             xo_parents_ack;
    logic             xo_child_valid;
    logic             xo_child_ack;
    logic             busy;
    logic             gen_start_pls;
    logic             gen_done_pls;
    logic             run_done_pls;
    logic [GEN_W-1:0] gen_cnt;
    logic [P_W-1:0]   issue_cnt;
    logic [P_W-1:0]   child_cnt;
    logic             err_ovf;

    ga_crossover_sched #(.P_W(P_W), .GEN_W(GEN_W)) dut (
        .clk               (clk),
        .sw_rst            (sw_rst),
        .cnfg_p            (cnfg_p),
        .cnfg_gen_max      (cnfg_gen_max),
        .start             (start),
        .pop_ready         (pop_ready),
        .sel_parents_valid (sel_parents_valid),
        .sel_parents_ack   (sel_parents_ack),
        .xo_parents_valid  (xo_parents_valid),
        .xo_parents_ack    (xo_parents_ack),
        .xo_child_valid    (xo_child_valid),
        .xo_child_ack      (xo_child_ack),
        .busy              (busy),
        .gen_start_pls     (gen_start_pls),
        .gen_done_pls      (gen_done_pls),
        .run_done_pls      (run_done_pls),
        .gen_cnt           (gen_cnt),
        .issue_cnt         (issue_cnt),
        .child_cnt         (child_cnt),
        .err_ovf           (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int gmax;
        bit busy;
        bit rd;
    } cfg_vec_t;

    typedef struct {
        bit sel;
        bit ack;
        bit xv;
        bit sa;
    } gate_vec_t;

    int tests;
    int fails;
    // Issue/child counts survive in IDLE until the next generation starts.
    int m_issued;
    int m_kids;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int v);
        return int'($urandom_range(0, 99)) < v;
    endfunction

    task automatic idle_inputs();
        start             = 1'b0;
        pop_ready         = 1'b0;
        sel_parents_valid = 1'b0;
        xo_parents_ack    = 1'b0;
        xo_child_valid    = 1'b0;
        xo_child_ack      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_xo_valid"}, int'(xo_parents_valid), 0);
        chk({tag, "_sel_ack"}, int'(sel_parents_ack), 0);
        chk({tag, "_gen_start"}, int'(gen_start_pls), 0);
        chk({tag, "_gen_done"}, int'(gen_done_pls), 0);
        chk({tag, "_run_done"}, int'(run_done_pls), 0);
        chk({tag, "_gen_cnt"}, int'(gen_cnt), 0);
        chk({tag, "_issue_cnt"}, int'(issue_cnt), 0);
        chk({tag, "_child_cnt"}, int'(child_cnt), 0);
        chk({tag, "_err_ovf"}, int'(err_ovf), 0);
    endtask

    // One complete run from IDLE, checked cycle by cycle. The model tracks generation
    // events: WAIT_POP entry, pop_ready sighting, the cycles at which p issues and
    // p children have been counted, and derives pulse timing from those.
    task automatic run_model(input int p, input int gmax, input int pop_lo,
                             input int sel_pct, input int ack_pct, input int kid_pct,
                             input int stall_at, input int stall_len);
        int n, issue_full, kid_full, wait_age, gens, ge;
        int dut_gs, dut_gd, dut_rd, dut_hs;
        bit waiting, in_gen, enter_wait, gen_pend, prev_pop;
        bit exp_gs, exp_gd, exp_rd, exp_busy, finished, xv, stall;
        int kq[$];

        kq.delete();
        waiting = 0; in_gen = 0; gen_pend = 0; finished = 0;
        issue_full = -1; kid_full = -1; wait_age = 0; gens = 0;
        dut_gs = 0; dut_gd = 0; dut_rd = 0; dut_hs = 0;

        @(negedge clk);
        chk("pre_start_busy", int'(busy), 0);
        idle_inputs();
        cnfg_p       = P_W'(p);
        cnfg_gen_max = GEN_W'(gmax);
        start        = 1'b1;
        pop_ready    = (pop_lo == 0);
        prev_pop     = pop_ready;
        enter_wait   = 1;
        exp_busy     = 1;

        for (n = 1; n < 3000 && !finished; n++) begin
            @(negedge clk);
            exp_gs = waiting && prev_pop;
            if (exp_gs) begin
                waiting = 0; in_gen = 1; m_issued = 0; m_kids = 0;
                issue_full = -1; kid_full = -1;
            end
            ge = (issue_full + 1 > kid_full) ? issue_full + 1 : kid_full;
            exp_gd = in_gen && issue_full >= 0 && kid_full >= 0 && (n == ge + 1);
            if (exp_gd) in_gen = 0;
            exp_rd = 0;
            if (gen_pend) begin
                gen_pend = 0;
                gens++;
                if (gens == gmax) begin
                    exp_rd = 1; exp_busy = 0; finished = 1;
                end else begin
                    enter_wait = 1;
                end
            end
            if (enter_wait) begin
                enter_wait = 0; waiting = 1; wait_age = 0;
            end
            if (exp_gd) gen_pend = 1;

            chk("gen_start_pls", int'(gen_start_pls), int'(exp_gs));
            chk("gen_done_pls", int'(gen_done_pls), int'(exp_gd));
            chk("run_done_pls", int'(run_done_pls), int'(exp_rd));
            chk("busy", int'(busy), int'(exp_busy));
            chk("gen_cnt", int'(gen_cnt), gens);
            chk("issue_cnt", int'(issue_cnt), m_issued);
            chk("child_cnt", int'(child_cnt), m_kids);
            chk("err_ovf", int'(err_ovf), 0);
            dut_gs += int'(gen_start_pls);
            dut_gd += int'(gen_done_pls);
            dut_rd += int'(run_done_pls);

            // Config and start are noise while busy; start must stay low once idle.
            start        = finished ? 1'b0 : ($urandom_range(0, 7) == 0);
            cnfg_p       = P_W'($urandom_range(0, 255));
            cnfg_gen_max = GEN_W'($urandom_range(0, 65535));
            if (waiting) begin
                pop_ready = (wait_age >= pop_lo);
                wait_age++;
            end else begin
                pop_ready = (pop_lo == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            sel_parents_valid = pct(sel_pct);
            xo_parents_ack    = pct(ack_pct);
            xo_child_valid    = 1'b0;
            if (kq.size() > 0) begin
                if (kq[0] <= n) xo_child_valid = 1'b1;
            end
            stall        = (n >= stall_at) && (n < stall_at + stall_len);
            xo_child_ack = !stall && pct(kid_pct);

            #1;
            xv = sel_parents_valid && in_gen && (m_issued < p);
            chk("xo_parents_valid", int'(xo_parents_valid), int'(xv));
            chk("sel_parents_ack", int'(sel_parents_ack), int'(xv && xo_parents_ack));
            dut_hs += int'(sel_parents_ack);
            if (xv && xo_parents_ack) begin
                m_issued++;
                kq.push_back(n + 1);
                if (m_issued == p) issue_full = n + 1;
            end
            if (xo_child_valid && xo_child_ack) begin
                void'(kq.pop_front());
                if (in_gen) begin
                    m_kids++;
                    if (m_kids == p) kid_full = n + 1;
                end
            end
            prev_pop = pop_ready;
        end

        @(negedge clk);
        idle_inputs();
        chk("run_gen_starts", dut_gs, gmax);
        chk("run_gen_dones", dut_gd, gmax);
        chk("run_done_count", dut_rd, 1);
        chk("run_issue_total", dut_hs, p * gmax);
    endtask

    cfg_vec_t  cfg_tab[5];
    gate_vec_t gate_tab[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; m_issued = 0; m_kids = 0;
        cfg_tab[0] = '{0, 5, 1'b0, 1'b1};
        cfg_tab[1] = '{3, 0, 1'b0, 1'b1};
        cfg_tab[2] = '{0, 0, 1'b0, 1'b1};
        cfg_tab[3] = '{2, 4, 1'b1, 1'b0};
        cfg_tab[4] = '{1, 1, 1'b1, 1'b0};
        gate_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        gate_tab[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        gate_tab[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        gate_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1};

        idle_inputs();
        cnfg_p = '0; cnfg_gen_max = '0;
        sw_rst = 1'b1;
        repeat (2) @(negedge clk);
        sw_rst = 1'b0;
        chk_all_zero("reset");

        // Best case: everything always ready.
        run_model(4, 1, 0, 100, 100, 100, -1, 0);
        chk("best_gen_cnt_final", int'(gen_cnt), 1);

        // Extra child after the generation is complete.
        xo_child_valid = 1'b1; xo_child_ack = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ovf_err_set", int'(err_ovf), 1);
        chk("ovf_child_held", int'(child_cnt), 4);
        @(negedge clk);
        chk("ovf_err_sticky", int'(err_ovf), 1);
        // Next start must clear err_ovf (checked on its first cycle).
        run_model(3, 3, 5, 100, 100, 100, -1, 0);

        // Mutation stalls mid-generation.
        run_model(5, 1, 0, 100, 100, 100, 4, 10);

        // Degenerate and normal configs from IDLE.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cnfg_p = P_W'(cfg_tab[i].p);
            cnfg_gen_max = GEN_W'(cfg_tab[i].gmax);
            start = 1'b1; sel_parents_valid = 1'b1; xo_parents_ack = 1'b0; pop_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("cfg_busy", int'(busy), int'(cfg_tab[i].busy));
            chk("cfg_run_done", int'(run_done_pls), int'(cfg_tab[i].rd));
            chk("cfg_gen_cnt", int'(gen_cnt), 0);
            chk("cfg_xo_valid", int'(xo_parents_valid), 0);
            @(negedge clk);
            chk("cfg_run_done_pulse", int'(run_done_pls), 0);
            chk("cfg_busy_2", int'(busy), int'(cfg_tab[i].busy));
            if (cfg_tab[i].busy) begin
                sw_rst = 1'b1;
                @(negedge clk);
                sw_rst = 1'b0;
                m_issued = 0; m_kids = 0;
            end
            idle_inputs();
        end

        // Gating table inside RUN, then reset with two pairs issued.
        @(negedge clk);
        cnfg_p = 8'd8; cnfg_gen_max = 16'd1; start = 1'b1; pop_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("gate_gen_start", int'(gen_start_pls), 1);
        for (int i = 0; i < 4; i++) begin
            sel_parents_valid = gate_tab[i].sel;
            xo_parents_ack    = gate_tab[i].ack;
            #1;
            chk("gate_xo_valid", int'(xo_parents_valid), int'(gate_tab[i].xv));
            chk("gate_sel_ack", int'(sel_parents_ack), int'(gate_tab[i].sa));
            @(negedge clk);
        end
        chk("gate_issue_cnt", int'(issue_cnt), 1);
        sel_parents_valid = 1'b1; xo_parents_ack = 1'b1;
        @(negedge clk);
        chk("rst_run_issue_cnt", int'(issue_cnt), 2);
        chk("rst_run_busy", int'(busy), 1);
        sw_rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_in_run");
        sw_rst = 1'b0;
        m_issued = 0; m_kids = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_gen_done", int'(gen_done_pls), 0);
            chk("post_rst_run_done", int'(run_done_pls), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        idle_inputs();

        for (int r = 0; r < 6; r++) begin
            run_model(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(40, 100)),
                      int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                      int'($urandom_range(2, 12)), int'($urandom_range(0, 8)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
